// File: rtl/physical_regfile_rdy_pkg.sv
// Shared definitions for the physical register file slice.
// Holds the geometry constants, the preg/data types and the write-match
// helper. The write arbiter uses the helper per destination register and
// the read path uses it per read port for bypass, so both resolve
// duplicate writes the same way (highest index wins).
package prf_pkg;

    localparam int REG_SIZE       = 64;
    localparam int REG_SIZE_WIDTH = $clog2(REG_SIZE);
    localparam int XLEN           = 64;
    localparam int NUM_RD         = 4;
    localparam int NUM_WR         = 4;
    localparam int NUM_ALLOC      = 2;

    typedef logic [REG_SIZE_WIDTH-1:0] preg_t;
    typedef logic [XLEN-1:0]           xlen_t;

    localparam preg_t PREG_ZERO = '0;

    typedef struct packed {
        logic  hit;
        xlen_t data;
    } wr_match_t;

    // Scans the writeback ports in ascending order so the highest-indexed
    // matching port overwrites earlier matches and therefore wins.
    function automatic wr_match_t wr_match(
        input preg_t                              addr,
        input logic [NUM_WR-1:0]                  valid,
        input logic [NUM_WR*REG_SIZE_WIDTH-1:0]   wr_addr,
        input logic [NUM_WR*XLEN-1:0]             wr_data
    );
        wr_match_t m;
        m = '0;
        for (int k = 0; k < NUM_WR; k++) begin
            if (valid[k] && (wr_addr[k*REG_SIZE_WIDTH +: REG_SIZE_WIDTH] == addr)) begin
                m.hit  = 1'b1;
                m.data = wr_data[k*XLEN +: XLEN];
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/physical_regfile_rdy_if.sv
// Bundle of the register file's read, writeback, allocation and status
// signals. The master modport is the pipeline side (issue, rename,
// writeback buses); the slave modport is the register file itself.
//   rd_addr_i/rd_data_o/rd_ready_o      : NUM_RD read ports
//   wr_valid_i/wr_addr_i/wr_data_i      : NUM_WR writeback ports
//   alloc_valid_i/alloc_addr_i          : NUM_ALLOC rename allocations
//   flush_i, err_clr_i                  : control
//   wr_conflict_o, alloc_conflict_o     : sticky error flags
interface physical_regfile_rdy_if import prf_pkg::*; ();

    logic [NUM_RD*REG_SIZE_WIDTH-1:0]    rd_addr_i;
    logic [NUM_RD*XLEN-1:0]              rd_data_o;
    logic [NUM_RD-1:0]                   rd_ready_o;
    logic [NUM_WR-1:0]                   wr_valid_i;
    logic [NUM_WR*REG_SIZE_WIDTH-1:0]    wr_addr_i;
    logic [NUM_WR*XLEN-1:0]              wr_data_i;
    logic [NUM_ALLOC-1:0]                alloc_valid_i;
    logic [NUM_ALLOC*REG_SIZE_WIDTH-1:0] alloc_addr_i;
    logic                                flush_i;
    logic                                err_clr_i;
    logic                                wr_conflict_o;
    logic                                alloc_conflict_o;

    modport master (
        output rd_addr_i, wr_valid_i, wr_addr_i, wr_data_i,
               alloc_valid_i, alloc_addr_i, flush_i, err_clr_i,
        input  rd_data_o, rd_ready_o, wr_conflict_o, alloc_conflict_o
    );

    modport slave (
        input  rd_addr_i, wr_valid_i, wr_addr_i, wr_data_i,
               alloc_valid_i, alloc_addr_i, flush_i, err_clr_i,
        output rd_data_o, rd_ready_o, wr_conflict_o, alloc_conflict_o
    );

endinterface

// File: rtl/physical_regfile_rdy_wr_arbiter.sv
// Writeback arbiter: turns NUM_WR writeback ports into a per-register
// write enable and write data, and detects two valid writes to the same
// nonzero preg in one cycle.
//   i_valid/i_addr/i_data : writeback ports
//   o_hit                 : per-preg write enable (P0 never enabled)
//   o_data                : per-preg winning write data
//   o_conflict            : same-cycle duplicate write to a nonzero preg
module prf_wr_arbiter import prf_pkg::*; (
    input  logic [NUM_WR-1:0]                i_valid,
    input  logic [NUM_WR*REG_SIZE_WIDTH-1:0] i_addr,
    input  logic [NUM_WR*XLEN-1:0]           i_data,
    output logic [REG_SIZE-1:0]              o_hit,
    output xlen_t                            o_data [REG_SIZE],
    output logic                             o_conflict
);

    wr_match_t w_match [REG_SIZE];

    // Per-register priority select; P0 is masked so it can never be written.
    always_comb begin
        o_hit = '0;
        for (int r = 0; r < REG_SIZE; r++) begin
            w_match[r] = wr_match(preg_t'(r), i_valid, i_addr, i_data);
            o_hit[r]   = w_match[r].hit && (r != 0);
            o_data[r]  = w_match[r].data;
        end
    end

    // Pairwise address compare of valid writes; P0 collisions are harmless
    // because those writes are dropped anyway.
    always_comb begin
        o_conflict = 1'b0;
        for (int i = 0; i < NUM_WR; i++) begin
            for (int j = i + 1; j < NUM_WR; j++) begin
                if (i_valid[i] && i_valid[j] &&
                    (i_addr[i*REG_SIZE_WIDTH +: REG_SIZE_WIDTH] ==
                     i_addr[j*REG_SIZE_WIDTH +: REG_SIZE_WIDTH]) &&
                    (i_addr[i*REG_SIZE_WIDTH +: REG_SIZE_WIDTH] != PREG_ZERO)) begin
                    o_conflict = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/physical_regfile_rdy.sv
// Physical register file with per-register ready scoreboard and optional
// same-cycle writeback-to-read bypass. P0 reads as zero and always ready.
//   clk    : clock
//   rst_n  : asynchronous active-low reset (data 0, ready all 1, flags 0)
//   bus    : slave side of physical_regfile_rdy_if (reads, writebacks,
//            allocations, flush, error clear, sticky error flags)
// BYPASS = 1 forwards a same-cycle valid write to matching read ports.
module physical_regfile_rdy import prf_pkg::*; #(
    parameter bit BYPASS = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    physical_regfile_rdy_if.slave  bus
);

    xlen_t                 r_data [REG_SIZE];
    logic [REG_SIZE-1:0]   r_ready;
    logic                  r_wr_conflict;
    logic                  r_alloc_conflict;

    logic [REG_SIZE-1:0]   w_wr_hit;
    xlen_t                 w_wr_data [REG_SIZE];
    logic                  w_wr_conflict;
    logic                  w_alloc_conflict;
    logic [REG_SIZE-1:0]   w_ready_nxt;
    wr_match_t             w_rd_match [NUM_RD];
    preg_t                 w_rd_addr [NUM_RD];
    logic [NUM_RD*XLEN-1:0] w_rd_data;
    logic [NUM_RD-1:0]     w_rd_ready;

    prf_wr_arbiter u_wr_arbiter (
        .i_valid    (bus.wr_valid_i),
        .i_addr     (bus.wr_addr_i),
        .i_data     (bus.wr_data_i),
        .o_hit      (w_wr_hit),
        .o_data     (w_wr_data),
        .o_conflict (w_wr_conflict)
    );

    // Ready scoreboard next state: writes set, allocs clear, flush sets all.
    // Later steps override earlier ones, so an alloc beats a same-cycle write.
    always_comb begin
        w_ready_nxt      = r_ready | w_wr_hit;
        w_alloc_conflict = 1'b0;
        for (int a = 0; a < NUM_ALLOC; a++) begin
            if (bus.alloc_valid_i[a] &&
                (bus.alloc_addr_i[a*REG_SIZE_WIDTH +: REG_SIZE_WIDTH] != PREG_ZERO)) begin
                w_ready_nxt[bus.alloc_addr_i[a*REG_SIZE_WIDTH +: REG_SIZE_WIDTH]] = 1'b0;
                if (w_wr_hit[bus.alloc_addr_i[a*REG_SIZE_WIDTH +: REG_SIZE_WIDTH]]) begin
                    w_alloc_conflict = 1'b1;
                end
            end
        end
        if (bus.flush_i) begin
            w_ready_nxt = '1;
        end
        w_ready_nxt[0] = 1'b1;
    end

    // Data array; P0 is never enabled by the arbiter so it keeps its reset zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < REG_SIZE; r++) begin
                r_data[r] <= '0;
            end
        end else begin
            for (int r = 0; r < REG_SIZE; r++) begin
                if (w_wr_hit[r]) begin
                    r_data[r] <= w_wr_data[r];
                end
            end
        end
    end

    // Ready bits and sticky error flags; a new error beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready          <= '1;
            r_wr_conflict    <= 1'b0;
            r_alloc_conflict <= 1'b0;
        end else begin
            r_ready          <= w_ready_nxt;
            r_wr_conflict    <= (r_wr_conflict & ~bus.err_clr_i) | w_wr_conflict;
            r_alloc_conflict <= (r_alloc_conflict & ~bus.err_clr_i) | w_alloc_conflict;
        end
    end

    // Combinational read ports: P0 guard first, then bypass, then the array.
    always_comb begin
        w_rd_data  = '0;
        w_rd_ready = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            w_rd_addr[k]  = bus.rd_addr_i[k*REG_SIZE_WIDTH +: REG_SIZE_WIDTH];
            w_rd_match[k] = wr_match(w_rd_addr[k], bus.wr_valid_i, bus.wr_addr_i, bus.wr_data_i);
            if (w_rd_addr[k] == PREG_ZERO) begin
                w_rd_data[k*XLEN +: XLEN] = '0;
                w_rd_ready[k]             = 1'b1;
            end else if (BYPASS && w_rd_match[k].hit) begin
                w_rd_data[k*XLEN +: XLEN] = w_rd_match[k].data;
                w_rd_ready[k]             = 1'b1;
            end else begin
                w_rd_data[k*XLEN +: XLEN] = r_data[w_rd_addr[k]];
                w_rd_ready[k]             = r_ready[w_rd_addr[k]];
            end
        end
    end

    assign bus.rd_data_o        = w_rd_data;
    assign bus.rd_ready_o       = w_rd_ready;
    assign bus.wr_conflict_o    = r_wr_conflict;
    assign bus.alloc_conflict_o = r_alloc_conflict;

endmodule

// File: tb/tb_physical_regfile_rdy.sv
// Directed bench for physical_regfile_rdy. Two instances share stimulus:
// busA drives a BYPASS=1 build, busB a BYPASS=0 build.
module tb_physical_regfile_rdy;
    import prf_pkg::*;

    logic clk;
    logic rst_n;
    int   nCompared;
    int   nMismatched;

    physical_regfile_rdy_if busA ();
    physical_regfile_rdy_if busB ();

    physical_regfile_rdy #(.BYPASS(1'b1)) dutA (.clk(clk), .rst_n(rst_n), .bus(busA));
    physical_regfile_rdy #(.BYPASS(1'b0)) dutB (.clk(clk), .rst_n(rst_n), .bus(busB));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        busA.rd_addr_i = '0;  busB.rd_addr_i = '0;
        busA.wr_valid_i = '0; busB.wr_valid_i = '0;
        busA.wr_addr_i = '0;  busB.wr_addr_i = '0;
        busA.wr_data_i = '0;  busB.wr_data_i = '0;
        busA.alloc_valid_i = '0; busB.alloc_valid_i = '0;
        busA.alloc_addr_i = '0;  busB.alloc_addr_i = '0;
        busA.flush_i = 1'b0; busB.flush_i = 1'b0;
        busA.err_clr_i = 1'b0; busB.err_clr_i = 1'b0;
    endtask

    task automatic drive_rd(input int port, input preg_t a);
        busA.rd_addr_i[port*REG_SIZE_WIDTH +: REG_SIZE_WIDTH] = a;
        busB.rd_addr_i[port*REG_SIZE_WIDTH +: REG_SIZE_WIDTH] = a;
    endtask

    task automatic drive_wr(input int port, input preg_t a, input xlen_t d);
        busA.wr_valid_i[port] = 1'b1; busB.wr_valid_i[port] = 1'b1;
        busA.wr_addr_i[port*REG_SIZE_WIDTH +: REG_SIZE_WIDTH] = a;
        busB.wr_addr_i[port*REG_SIZE_WIDTH +: REG_SIZE_WIDTH] = a;
        busA.wr_data_i[port*XLEN +: XLEN] = d;
        busB.wr_data_i[port*XLEN +: XLEN] = d;
    endtask

    task automatic drive_alloc(input int port, input preg_t a);
        busA.alloc_valid_i[port] = 1'b1; busB.alloc_valid_i[port] = 1'b1;
        busA.alloc_addr_i[port*REG_SIZE_WIDTH +: REG_SIZE_WIDTH] = a;
        busB.alloc_addr_i[port*REG_SIZE_WIDTH +: REG_SIZE_WIDTH] = a;
    endtask

    task automatic test_reset();
        xlen_t d;
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        for (int r = 0; r < REG_SIZE; r++) begin
            for (int k = 0; k < NUM_RD; k++) drive_rd(k, preg_t'((r + k) % REG_SIZE));
            #1;
            for (int k = 0; k < NUM_RD; k++) begin
                d = busA.rd_data_o[k*XLEN +: XLEN];
                nCompared++;
                if (d !== 64'd0) begin
                    nMismatched++;
                    $display("[TB] FAIL reset_data preg %0d port %0d: got %h want 0", (r + k) % REG_SIZE, k, d);
                end
                nCompared++;
                if (busA.rd_ready_o[k] !== 1'b1) begin
                    nMismatched++;
                    $display("[TB] FAIL reset_ready preg %0d port %0d: got %b want 1", (r + k) % REG_SIZE, k, busA.rd_ready_o[k]);
                end
            end
        end
        nCompared++;
        if ({busA.wr_conflict_o, busA.alloc_conflict_o} !== 2'b00) begin
            nMismatched++;
            $display("[TB] FAIL reset_flags: got %b want 00", {busA.wr_conflict_o, busA.alloc_conflict_o});
        end
    endtask

    task automatic test_alloc_writeback();
        clear_inputs();
        drive_alloc(0, 6'd5);
        tick();
        clear_inputs();
        drive_rd(0, 6'd5);
        #1;
        nCompared++;
        if (busA.rd_ready_o[0] !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL alloc_ready P5: got %b want 0", busA.rd_ready_o[0]);
        end
        tick();
        tick();
        drive_wr(0, 6'd5, 64'hDEAD_BEEF);
        #1;
        nCompared++;
        if (busA.rd_data_o[63:0] !== 64'hDEAD_BEEF || busA.rd_ready_o[0] !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL bypass P5: got %h/%b want deadbeef/1", busA.rd_data_o[63:0], busA.rd_ready_o[0]);
        end
        tick();
        busA.wr_valid_i = '0; busB.wr_valid_i = '0;
        #1;
        nCompared++;
        if (busA.rd_data_o[63:0] !== 64'hDEAD_BEEF || busA.rd_ready_o[0] !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL array P5: got %h/%b want deadbeef/1", busA.rd_data_o[63:0], busA.rd_ready_o[0]);
        end
    endtask

    task automatic test_wr_collision();
        clear_inputs();
        drive_wr(0, 6'd9, 64'h11);
        drive_wr(3, 6'd9, 64'h33);
        drive_rd(1, 6'd9);
        #1;
        nCompared++;
        if (busA.rd_data_o[XLEN +: XLEN] !== 64'h33) begin
            nMismatched++;
            $display("[TB] FAIL bypass_priority P9: got %h want 33", busA.rd_data_o[XLEN +: XLEN]);
        end
        tick();
        busA.wr_valid_i = '0; busB.wr_valid_i = '0;
        #1;
        nCompared++;
        if (busA.rd_data_o[XLEN +: XLEN] !== 64'h33) begin
            nMismatched++;
            $display("[TB] FAIL collision_data P9: got %h want 33", busA.rd_data_o[XLEN +: XLEN]);
        end
        tick();
        nCompared++;
        if (busA.wr_conflict_o !== 1'b1 || busA.alloc_conflict_o !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL wr_conflict_sticky: got %b%b want 10", busA.wr_conflict_o, busA.alloc_conflict_o);
        end
        busA.err_clr_i = 1'b1; busB.err_clr_i = 1'b1;
        tick();
        busA.err_clr_i = 1'b0; busB.err_clr_i = 1'b0;
        nCompared++;
        if (busA.wr_conflict_o !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL wr_conflict_clear: got %b want 0", busA.wr_conflict_o);
        end
        drive_wr(1, 6'd10, 64'h1);
        drive_wr(2, 6'd10, 64'h2);
        busA.err_clr_i = 1'b1; busB.err_clr_i = 1'b1;
        tick();
        clear_inputs();
        #1;
        nCompared++;
        if (busA.wr_conflict_o !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL set_beats_clear: got %b want 1", busA.wr_conflict_o);
        end
        busA.err_clr_i = 1'b1; busB.err_clr_i = 1'b1;
        tick();
        busA.err_clr_i = 1'b0; busB.err_clr_i = 1'b0;
    endtask

    task automatic test_p0_guard();
        clear_inputs();
        drive_wr(0, 6'd0, 64'hFFFF);
        drive_wr(2, 6'd0, 64'hEEEE);
        drive_alloc(0, 6'd0);
        drive_rd(2, 6'd0);
        #1;
        nCompared++;
        if (busA.rd_data_o[2*XLEN +: XLEN] !== 64'd0 || busA.rd_ready_o[2] !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL p0_bypass: got %h/%b want 0/1", busA.rd_data_o[2*XLEN +: XLEN], busA.rd_ready_o[2]);
        end
        tick();
        busA.wr_valid_i = '0; busB.wr_valid_i = '0;
        busA.alloc_valid_i = '0; busB.alloc_valid_i = '0;
        #1;
        nCompared++;
        if (busA.rd_data_o[2*XLEN +: XLEN] !== 64'd0 || busA.rd_ready_o[2] !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL p0_array: got %h/%b want 0/1", busA.rd_data_o[2*XLEN +: XLEN], busA.rd_ready_o[2]);
        end
        nCompared++;
        if ({busA.wr_conflict_o, busA.alloc_conflict_o} !== 2'b00) begin
            nMismatched++;
            $display("[TB] FAIL p0_flags: got %b%b want 00", busA.wr_conflict_o, busA.alloc_conflict_o);
        end
        drive_alloc(0, 6'd12);
        drive_alloc(1, 6'd12);
        drive_rd(3, 6'd12);
        tick();
        busA.alloc_valid_i = '0; busB.alloc_valid_i = '0;
        #1;
        nCompared++;
        if (busA.rd_ready_o[3] !== 1'b0 || busA.alloc_conflict_o !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL dup_alloc: got ready %b flag %b want 0 0", busA.rd_ready_o[3], busA.alloc_conflict_o);
        end
    endtask

    task automatic test_alloc_wb_collision();
        clear_inputs();
        drive_alloc(1, 6'd7);
        drive_wr(1, 6'd7, 64'h42);
        tick();
        clear_inputs();
        drive_rd(0, 6'd7);
        drive_rd(1, 6'd20);
        #1;
        nCompared++;
        if (busA.rd_data_o[63:0] !== 64'h42 || busA.rd_ready_o[0] !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL alloc_wb P7: got %h/%b want 42/0", busA.rd_data_o[63:0], busA.rd_ready_o[0]);
        end
        nCompared++;
        if (busA.alloc_conflict_o !== 1'b1 || busA.wr_conflict_o !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL alloc_conflict: got %b%b want 10", busA.alloc_conflict_o, busA.wr_conflict_o);
        end
        busA.flush_i = 1'b1; busB.flush_i = 1'b1;
        drive_alloc(0, 6'd20);
        tick();
        busA.flush_i = 1'b0; busB.flush_i = 1'b0;
        busA.alloc_valid_i = '0; busB.alloc_valid_i = '0;
        #1;
        nCompared++;
        if (busA.rd_ready_o[1:0] !== 2'b11 || busA.rd_data_o[63:0] !== 64'h42) begin
            nMismatched++;
            $display("[TB] FAIL flush: got ready %b data %h want 11/42", busA.rd_ready_o[1:0], busA.rd_data_o[63:0]);
        end
        busA.err_clr_i = 1'b1; busB.err_clr_i = 1'b1;
        tick();
        busA.err_clr_i = 1'b0; busB.err_clr_i = 1'b0;
    endtask

    task automatic test_no_bypass();
        clear_inputs();
        drive_wr(0, 6'd3, 64'hAAAA);
        tick();
        clear_inputs();
        drive_alloc(0, 6'd3);
        tick();
        clear_inputs();
        drive_wr(2, 6'd3, 64'hBBBB);
        drive_rd(0, 6'd3);
        #1;
        nCompared++;
        if (busB.rd_data_o[63:0] !== 64'hAAAA || busB.rd_ready_o[0] !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL nobypass_old P3: got %h/%b want aaaa/0", busB.rd_data_o[63:0], busB.rd_ready_o[0]);
        end
        nCompared++;
        if (busA.rd_data_o[63:0] !== 64'hBBBB || busA.rd_ready_o[0] !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL bypass_new P3: got %h/%b want bbbb/1", busA.rd_data_o[63:0], busA.rd_ready_o[0]);
        end
        tick();
        busA.wr_valid_i = '0; busB.wr_valid_i = '0;
        #1;
        nCompared++;
        if (busB.rd_data_o[63:0] !== 64'hBBBB || busB.rd_ready_o[0] !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL nobypass_next P3: got %h/%b want bbbb/1", busB.rd_data_o[63:0], busB.rd_ready_o[0]);
        end
    endtask

    task automatic test_async_reset();
        clear_inputs();
        drive_wr(0, 6'd11, 64'h5);
        drive_wr(1, 6'd11, 64'h6);
        drive_alloc(0, 6'd30);
        tick();
        clear_inputs();
        drive_rd(0, 6'd3);
        drive_rd(1, 6'd30);
        drive_wr(3, 6'd3, 64'h1234);
        #1;
        nCompared++;
        if (busB.wr_conflict_o !== 1'b1 || busB.rd_ready_o[1] !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL pre_reset_state: got flag %b ready %b want 1 0", busB.wr_conflict_o, busB.rd_ready_o[1]);
        end
        rst_n = 1'b0;
        #1;
        nCompared++;
        if (busB.rd_data_o[63:0] !== 64'd0 || busB.rd_ready_o[1:0] !== 2'b11 || busB.wr_conflict_o !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL async_reset: got %h ready %b flag %b want 0 11 0", busB.rd_data_o[63:0], busB.rd_ready_o[1:0], busB.wr_conflict_o);
        end
        tick();
        clear_inputs();
        drive_rd(0, 6'd3);
        drive_rd(2, 6'd5);
        #1;
        nCompared++;
        if (busA.rd_data_o[63:0] !== 64'd0 || busA.rd_data_o[2*XLEN +: XLEN] !== 64'd0) begin
            nMismatched++;
            $display("[TB] FAIL pending_lost: got P3 %h P5 %h want 0 0", busA.rd_data_o[63:0], busA.rd_data_o[2*XLEN +: XLEN]);
        end
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        rst_n       = 1'b0;
        clear_inputs();
        test_reset();
        test_alloc_writeback();
        test_wr_collision();
        test_p0_guard();
        test_alloc_wb_collision();
        test_no_bypass();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
